// File: rtl/stage0c3lw_report_collector.sv
// stage0c3lw_report_collector
//   Captures every run cycle of the cluster-3 lw stage-0 automata stage that
//   carries at least one report (or a stream restart). Each such cycle is
//   time-stamped and queued as a record in a circular FIFO, which drains to
//   the monitor report sink over a valid/ready handshake.
//
// Optional feature: define STAGE0C3LW_RPT_SYMBOL_EN to also store in_symbols
//   with each record and expose it on rpt_symbol.
//
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   run                 stage enable; captures and counting only when 1
//   in_reset            stream restart; pushes an eos record, zeroes counter
//   in_symbols[7:0]     stage symbol (stored only with the optional feature)
//   report_vec[39:0]    4 report bits per automaton, automaton n at [4n+3:4n]
//   rpt_valid/ready     head-record handshake to the sink
//   rpt_vec/cycle/eos   head record fields (0 while rpt_valid=0)
//   rpt_symbol[7:0]     head record symbol (optional feature only)
//   ovf                 sticky overflow flag
//   drop_cnt            saturating count of discarded records
//   fifo_level          current FIFO occupancy
module stage0c3lw_report_collector #(
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32,
    parameter int DROP_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              in_reset,
    input  logic [7:0]        in_symbols,
    input  logic [39:0]       report_vec,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [39:0]       rpt_vec,
    output logic [CNT_W-1:0]  rpt_cycle,
    output logic              rpt_eos,
`ifdef STAGE0C3LW_RPT_SYMBOL_EN
    output logic [7:0]        rpt_symbol,
`endif
    output logic              ovf,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [AW:0]       fifo_level
);

    typedef struct packed {
`ifdef STAGE0C3LW_RPT_SYMBOL_EN
        logic [7:0]       sym;
`endif
        logic             eos;
        logic [CNT_W-1:0] cycle;
        logic [39:0]      vec;
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             wr_rec;
    rec_t             head;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_req, pop, full, push_ok, drop;

`ifndef STAGE0C3LW_RPT_SYMBOL_EN
    logic unused_symbols;
    assign unused_symbols = ^in_symbols;
`endif

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == (AW+1)'(DEPTH));
    assign rpt_valid  = (fifo_level != '0);

    assign push_req = run && ((|report_vec) || in_reset);
    assign pop      = rpt_valid && rpt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        wr_rec       = '0;
        wr_rec.vec   = report_vec;
        wr_rec.cycle = cnt;
        wr_rec.eos   = in_reset;
`ifdef STAGE0C3LW_RPT_SYMBOL_EN
        wr_rec.sym   = in_symbols;
`endif
    end

    // Storage needs no reset: nothing is visible until a write lands.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_rec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (run) cnt <= in_reset ? '0 : cnt + 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // Head fields are forced to 0 when empty so reset shows all-zero outputs.
    assign head      = mem[rd_ptr[AW-1:0]];
    assign rpt_vec   = rpt_valid ? head.vec   : '0;
    assign rpt_cycle = rpt_valid ? head.cycle : '0;
    assign rpt_eos   = rpt_valid ? head.eos   : 1'b0;
`ifdef STAGE0C3LW_RPT_SYMBOL_EN
    assign rpt_symbol = rpt_valid ? head.sym  : 8'h00;
`endif

endmodule
